onehot_pulse_decoder: RTL and testbench
=======================================

ONEHOT_PULSE_DECODER -- requirements
Module: onehot_pulse_decoder

Interface
REQ-001 Parameter PULSE_CYCLES, default 4, number of cycles each one-hot output is driven; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 1, number of all-zero cycles inserted after each pulse; legal range 0..255.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  request carrying in_code is present.
REQ-006 Port in_code  input  2  binary index to decode (1:MSB, 0:LSB).
REQ-007 Port in_ready  output  1  block can accept a request this cycle.
REQ-008 Port y  output  4  registered one-hot output; y[i]=1 when code i is being driven.
REQ-009 Port busy  output  1  high whenever state is not IDLE.
REQ-010 Port done  output  1  single-cycle strobe marking the last driven cycle of a pulse.

Function
REQ-011 States SHALL be IDLE, DRIVE, GAP; 2-bit state register plus 8-bit down-counter.
REQ-012 in_ready SHALL equal (state==IDLE), decoded combinationally from the state register.
REQ-013 A transfer occurs on a rising edge where in_valid and in_ready are both 1; in_code is latched on that edge.
REQ-014 On transfer, the next state SHALL be DRIVE, counter loaded with PULSE_CYCLES-1, and y SHALL become 1<<in_code from the same edge (latency 1 cycle).
REQ-015 Code mapping: 00->0001, 01->0010, 10->0100, 11->1000; exactly one bit of y high in DRIVE.
REQ-016 In DRIVE, y SHALL hold its value; counter decrements each cycle while nonzero.
REQ-017 done SHALL be 1 exactly in the DRIVE cycle where counter==0, and 0 otherwise.
REQ-018 From DRIVE with counter==0: GAP_CYCLES==0 -> IDLE; otherwise GAP, counter loaded with GAP_CYCLES-1; y SHALL be 4'b0000 from that edge.
REQ-019 In GAP, y SHALL be 0; at counter==0 the next state SHALL be IDLE.
REQ-020 y SHALL be 4'b0000 in IDLE and GAP; never more than one bit high in any cycle.
REQ-021 in_valid and in_code are ignored while in_ready=0; no queuing; a requester holds in_valid until a transfer occurs.
REQ-022 Minimum request period SHALL be PULSE_CYCLES+GAP_CYCLES+1 cycles.
REQ-023 PULSE_CYCLES=1: DRIVE lasts one cycle with done high in that cycle.

Reset
REQ-024 rst_n low SHALL force, without waiting for clk: state=IDLE, counter=0, y=0000, done=0, busy=0; in_ready reads 1.
REQ-025 Reset asserted mid-DRIVE or mid-GAP SHALL abort the pulse immediately; no done is generated for it.
REQ-026 The first transfer is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro ONEHOT_DEC_SCAN_EN, when defined, SHALL add port scan_en  input  1  auto-scan enable, and a 2-bit scan pointer reset to 0.
REQ-028 With the macro defined, in IDLE with scan_en=1 and in_valid=0, the block SHALL self-issue a transfer of code=scan pointer; the pointer increments with wrap 3->0; in_ready stays 0 on that cycle.
REQ-029 With the macro defined, in_valid=1 SHALL take priority over scan in IDLE; the pointer is unchanged on external transfers.
REQ-030 Without the macro, scan_en and the pointer SHALL not exist; behaviour is REQ-011..026 only.

Verification
REQ-031 Reset then in_valid=1, in_code=10 for one cycle (defaults) -> y=0100 for cycles 1..4 after the edge, done high in cycle 4, y=0000 in cycle 5, in_ready=1 in cycle 6.
REQ-032 Sweep codes 00,01,10,11 back-to-back with in_valid held -> y shows 0001,0010,0100,1000 in order, with one 0000 gap cycle between pulses, period 6 cycles.
REQ-033 During DRIVE, change in_code to 11 with in_valid=1 -> y unchanged and in_ready=0 until IDLE.
REQ-034 Assert rst_n=0 mid-DRIVE between clock edges -> y=0000 immediately, done never asserts, in_ready=1.
REQ-035 PULSE_CYCLES=1, GAP_CYCLES=0, in_valid held with code 01 -> y alternates 0010/0000, done high every second cycle.
REQ-036 With ONEHOT_DEC_SCAN_EN and scan_en=1, in_valid=0 -> y cycles 0001,0010,0100,1000,0001; inject in_valid with code 11 -> 1000 issued next and scan resumes at the held pointer.

Source files
------------

// File: rtl/onehot_pulse_decoder.sv
// Decodes a 2-bit code into a 4-bit one-hot pulse held PULSE_CYCLES cycles,
// followed by GAP_CYCLES all-zero cycles. Define ONEHOT_DEC_SCAN_EN to add auto-scan.
module onehot_pulse_decoder #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef ONEHOT_DEC_SCAN_EN
  input  logic       scan_en,
`endif
  input  logic       in_valid,
  input  logic [1:0] in_code,
  output logic       in_ready,
  output logic [3:0] y,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [3:0] y_next;
  logic       take;
  logic [1:0] take_code;
  logic       idle;

  assign idle = (state == IDLE);

`ifdef ONEHOT_DEC_SCAN_EN
  logic [1:0] scan_ptr;
  logic       scan_go;

  // External requests win; scan only self-issues when nobody is asking.
  assign scan_go   = idle && scan_en && !in_valid;
  assign take      = idle && (in_valid || scan_en);
  assign take_code = in_valid ? in_code : scan_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr <= 2'd0;
    end else if (scan_go) begin
      scan_ptr <= scan_ptr + 2'd1;
    end
  end
`else
  assign take      = idle && in_valid;
  assign take_code = in_code;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      y     <= 4'b0000;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      y     <= y_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    y_next     = y;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_next = DRIVE;
          cnt_next   = PULSE_LOAD;
          y_next     = 4'b0001 << take_code;
        end
      end
      DRIVE: begin
        if (cnt != 8'd0) begin
          cnt_next = cnt - 8'd1;
        end else begin
          y_next = 4'b0000;
          if (GAP_CYCLES == 0) begin
            state_next = IDLE;
            cnt_next   = 8'd0;
          end else begin
            state_next = GAP;
            cnt_next   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (cnt != 8'd0) begin
          cnt_next = cnt - 8'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
        y_next     = 4'b0000;
      end
    endcase
  end

  always_comb begin
`ifdef ONEHOT_DEC_SCAN_EN
    in_ready = idle && !scan_go;
`else
    in_ready = idle;
`endif
    busy = !idle;
    done = (state == DRIVE) && (cnt == 8'd0);
  end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Self-checking bench: vector table, hand sequences for timing corners and
// reset abort, and a randomized run against a cycle-count reference model.
module tb_onehot_pulse_decoder;

  localparam int P = 4;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_code;
  logic       in_ready, busy, done;
  logic [3:0] y;

  logic       f_valid;
  logic [1:0] f_code;
  logic       f_ready, f_busy, f_done;
  logic [3:0] f_y;

`ifdef ONEHOT_DEC_SCAN_EN
  logic scan_en;
  logic f_scan_en;
`endif

  always #5 clk = ~clk;

  onehot_pulse_decoder #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef ONEHOT_DEC_SCAN_EN
    .scan_en  (scan_en),
`endif
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (in_ready),
    .y        (y),
    .busy     (busy),
    .done     (done)
  );

  onehot_pulse_decoder #(.PULSE_CYCLES(1), .GAP_CYCLES(0)) u_fast (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef ONEHOT_DEC_SCAN_EN
    .scan_en  (f_scan_en),
`endif
    .in_valid (f_valid),
    .in_code  (f_code),
    .in_ready (f_ready),
    .y        (f_y),
    .busy     (f_busy),
    .done     (f_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] c;
    logic [3:0] ey;
    logic       ed;
    logic       er;
  } vec_t;

  vec_t vecs[12];

  // Reference model: k counts cycles since the accepting edge (0 = idle).
  int         k;
  logic [1:0] mcode;

  task automatic model_step(input logic v, input logic [1:0] c);
    if (k == 0) begin
      if (v) begin
        k     = 1;
        mcode = c;
      end
    end else begin
      k = (k == P + G) ? 0 : k + 1;
    end
  endtask

`ifdef ONEHOT_DEC_SCAN_EN
  task automatic wait_pulse(output logic [3:0] yv);
    int n = 0;
    while (y != 4'b0000 && n < 40) begin tick(); n++; end
    while (y == 4'b0000 && n < 40) begin tick(); n++; end
    check("scan_wait_timeout", 32'(n >= 40), 32'd0);
    yv = y;
  endtask
`endif

  initial begin
    // inputs applied -> outputs expected after the following edge
    vecs[0]  = '{1'b1, 2'd2, 4'b0100, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd3, 4'b0100, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'd3, 4'b0100, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'd3, 4'b0100, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 2'd0, 4'b0001, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 4'b0001, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'd1, 4'b0001, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 4'b0001, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 2'd1, 4'b0000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'd1, 4'b0000, 1'b0, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_code  = 2'd0;
    f_valid  = 1'b0;
    f_code   = 2'd0;
`ifdef ONEHOT_DEC_SCAN_EN
    scan_en   = 1'b0;
    f_scan_en = 1'b0;
`endif

    repeat (3) tick();
    check("rst_y", 32'(y), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Vector table; row 0 transfers on the first edge after reset release.
    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].v;
      in_code  = vecs[i].c;
      tick();
      check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].ey));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].ed));
      check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].er));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(!vecs[i].er));
    end
    in_valid = 1'b0;

    // Back-to-back sweep of all four codes, period P+G+1.
    in_valid = 1'b1;
    in_code  = 2'd0;
    for (int j = 0; j < 24; j++) begin
      tick();
      check($sformatf("sweep%0d_y", j), 32'(y),
            (j % 6 < P) ? (32'd1 << (j / 6)) : 32'd0);
      if (j % 6 == 5) begin
        check($sformatf("sweep%0d_ready", j), 32'(in_ready), 32'd1);
        if (j == 23) in_valid = 1'b0;
        else         in_code  = 2'(j / 6 + 1);
      end
    end

    // Single-cycle pulse, no gap: y alternates, done every other cycle.
    f_valid = 1'b1;
    f_code  = 2'd1;
    for (int j = 0; j < 8; j++) begin
      tick();
      check($sformatf("fast%0d_y", j), 32'(f_y), (j % 2 == 0) ? 32'h2 : 32'h0);
      check($sformatf("fast%0d_done", j), 32'(f_done), 32'(j % 2 == 0));
      check($sformatf("fast%0d_ready", j), 32'(f_ready), 32'(j % 2 == 1));
    end
    f_valid = 1'b0;
    tick();

    // Reset between edges mid-DRIVE aborts the pulse with no done.
    in_valid = 1'b1;
    in_code  = 2'd1;
    tick();
    check("abort_pre_y", 32'(y), 32'h2);
    in_valid = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("abort_y", 32'(y), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      check($sformatf("abort_post%0d_done", j), 32'(done), 32'd0);
      check($sformatf("abort_post%0d_y", j), 32'(y), 32'd0);
    end

    // Randomized run against the reference model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    k     = 0;
    mcode = 2'd0;
    for (int n = 0; n < 400; n++) begin
      logic       v;
      logic [1:0] c;
      v = ($urandom % 3) != 0;
      c = 2'($urandom);
      in_valid = v;
      in_code  = c;
      @(posedge clk);
      model_step(v, c);
      #1;
      check("rand_y", 32'(y), (k >= 1 && k <= P) ? (32'd1 << mcode) : 32'd0);
      check("rand_done", 32'(done), 32'(k == P));
      check("rand_ready", 32'(in_ready), 32'(k == 0));
      check("rand_busy", 32'(busy), 32'(k != 0));
    end
    in_valid = 1'b0;

`ifdef ONEHOT_DEC_SCAN_EN
    begin
      logic [3:0] pv;
      rst_n = 1'b0;
      tick();
      rst_n   = 1'b1;
      scan_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
        wait_pulse(pv);
        check($sformatf("scan%0d_y", i), 32'(pv), 32'd1 << (i % 4));
        check($sformatf("scan%0d_ready", i), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b1;
      in_code  = 2'd3;
      wait_pulse(pv);
      check("scan_inject_y", 32'(pv), 32'h8);
      in_valid = 1'b0;
      wait_pulse(pv);
      check("scan_resume_y", 32'(pv), 32'h2);
      scan_en = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
